// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// around the shared datapath, drives immediate select, write strobes and mux
// selects, and handshakes with imem/dmem via req/ready with an optional watchdog.
module rv32_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic [2:0]  ext_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic             WD_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_e             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               funct7b5_q, funct7b5_d;
  logic [2:0]         ext_op_q, ext_op_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   wait_inc;
  logic               is_store;
  logic               unused_ok;

  // funct3/funct7[5] are held for the ALU-control decode outside this block.
  assign unused_ok = ^{instr[31], instr[29:15], instr[11:7], funct3_q, funct7b5_q};

  function automatic logic [2:0] ext_of(input logic [6:0] opc);
    case (opc)
      OPC_STORE:           return 3'b010;
      OPC_BRANCH:          return 3'b011;
      OPC_LUI, OPC_AUIPC:  return 3'b001;
      OPC_JAL:             return 3'b100;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  assign wait_inc = wait_cnt_q + 1'b1;
  assign is_store = (opcode_q == OPC_STORE);
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign halted   = (state_q == ST_HALT);

  // State and latched-field registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_FETCH;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      ext_op_q   <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      ext_op_q   <= ext_op_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and datapath control; outputs are masked while reset is held.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    ext_op_d   = ext_op_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    wait_cnt_d = '0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    ext_op     = ext_op_q;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'b00;

    if (rstn) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we      = 1'b1;
            opcode_d   = instr[6:0];
            funct3_d   = instr[14:12];
            funct7b5_d = instr[30];
            state_d    = ST_DECODE;
          end else if (WD_EN) begin
            if (wait_inc == LIMIT) begin
              timeout_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              wait_cnt_d = wait_inc;
            end
          end
        end
        ST_DECODE: begin
          ext_op   = ext_of(opcode_q);
          ext_op_d = ext_of(opcode_q);
          if (opcode_q == OPC_SYSTEM) begin
            state_d = ST_HALT;
          end else if (is_legal(opcode_q)) begin
            state_d = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        end
        ST_EXEC: begin
          case (opcode_q)
            OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_sel = 1'b1;
            OPC_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            default: ;
          endcase
          if (opcode_q == OPC_BRANCH) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            state_d = ST_FETCH;
          end else if (opcode_q == OPC_LOAD || is_store) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready) begin
            if (is_store) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (WD_EN) begin
            if (wait_inc == LIMIT) begin
              timeout_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              wait_cnt_d = wait_inc;
            end
          end
        end
        ST_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (opcode_q)
            OPC_LOAD:          wb_sel = 2'b01;
            OPC_JAL, OPC_JALR: wb_sel = 2'b10;
            OPC_LUI:           wb_sel = 2'b11;
            default:           wb_sel = 2'b00;
          endcase
          case (opcode_q)
            OPC_JAL:  pc_sel = 2'b01;
            OPC_JALR: pc_sel = 2'b10;
            default:  pc_sel = 2'b00;
          endcase
          state_d = ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Randomized bench for rv32_multicycle_ctrl: builds per-instruction expected
// output traces from the instruction-class rules and compares every cycle.
module tb_rv32_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_we, alu_a_sel, alu_b_sel, pc_we;
  logic [2:0]  ext_op, state;
  logic [1:0]  pc_sel, wb_sel;
  logic        dmem_req, dmem_we, reg_we, illegal, timeout, halted;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_we(ir_we), .ext_op(ext_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .illegal(illegal),
    .timeout(timeout), .halted(halted)
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic [2:0] ext_op;
    logic       a_sel;
    logic       b_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] st;
    logic       illegal;
    logic       timeout;
    logic       halted;
  } obs_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        taken;
  } stim_t;

  obs_t        exp_q[$];
  stim_t       stim_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [2:0]  m_ext;
  logic [31:0] cur_ins;
  logic        m_halt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.ext_op = m_ext;
    return o;
  endfunction

  function automatic logic rb();
    int unsigned r;
    r = $urandom();
    return r[0];
  endfunction

  task automatic push(input obs_t o, input logic imr, input logic dmr, input logic tk);
    stim_t s;
    s.instr      = imr ? cur_ins : $urandom();
    s.imem_ready = imr;
    s.dmem_ready = dmr;
    s.taken      = tk;
    exp_q.push_back(o);
    stim_q.push_back(s);
  endtask

  task automatic push_halt(input logic ill, input logic to);
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      o = blank(3'd7);
      o.halted = 1'b1;
      o.illegal = ill;
      o.timeout = to;
      push(o, rb(), rb(), rb());
    end
    m_halt = 1'b1;
  endtask

  // Expected trace from instruction-class rules: fetch waits, accept, decode,
  // then the class-specific tail (branch resolves in EXEC, stores finish in MEM).
  task automatic build(input logic [31:0] ins, input int iw, input int dw, input logic tk);
    obs_t o;
    logic [6:0] opc;
    logic legal, mem, st;
    opc = ins[6:0];
    cur_ins = ins;
    for (int i = 0; i < ((iw >= 4) ? 4 : iw); i++) begin
      o = blank(3'd0); o.imem_req = 1'b1;
      push(o, 1'b0, rb(), rb());
    end
    if (iw >= 4) begin push_halt(1'b0, 1'b1); return; end
    o = blank(3'd0); o.imem_req = 1'b1; o.ir_we = 1'b1;
    push(o, 1'b1, rb(), rb());
    legal = 1'b1;
    case (opc)
      7'h03, 7'h13, 7'h67, 7'h33: m_ext = 3'd0;
      7'h23:                      m_ext = 3'd2;
      7'h63:                      m_ext = 3'd3;
      7'h37, 7'h17:               m_ext = 3'd1;
      7'h6F:                      m_ext = 3'd4;
      default: begin m_ext = 3'd0; legal = 1'b0; end
    endcase
    o = blank(3'd1);
    push(o, rb(), rb(), rb());
    if (!legal) begin push_halt(opc != 7'h73, 1'b0); return; end
    o = blank(3'd2);
    o.a_sel = (opc == 7'h17);
    o.b_sel = (opc inside {7'h13, 7'h03, 7'h23, 7'h17, 7'h67});
    if (opc == 7'h63) begin
      o.pc_we = 1'b1; o.pc_sel = tk ? 2'd1 : 2'd0;
      push(o, rb(), rb(), tk);
      return;
    end
    push(o, rb(), rb(), rb());
    mem = (opc == 7'h03) || (opc == 7'h23);
    st  = (opc == 7'h23);
    if (mem) begin
      for (int i = 0; i < ((dw >= 4) ? 4 : dw); i++) begin
        o = blank(3'd3); o.dmem_req = 1'b1; o.dmem_we = st;
        push(o, rb(), 1'b0, rb());
      end
      if (dw >= 4) begin push_halt(1'b0, 1'b1); return; end
      o = blank(3'd3); o.dmem_req = 1'b1; o.dmem_we = st; o.pc_we = st;
      push(o, rb(), 1'b1, rb());
      if (st) return;
    end
    o = blank(3'd4); o.reg_we = 1'b1; o.pc_we = 1'b1;
    o.wb_sel = (opc == 7'h03) ? 2'd1 : (opc == 7'h6F || opc == 7'h67) ? 2'd2 :
               (opc == 7'h37) ? 2'd3 : 2'd0;
    o.pc_sel = (opc == 7'h6F) ? 2'd1 : (opc == 7'h67) ? 2'd2 : 2'd0;
    push(o, rb(), rb(), rb());
  endtask

  function automatic obs_t sample();
    return {imem_req, ir_we, ext_op, alu_a_sel, alu_b_sel, pc_we, pc_sel,
            dmem_req, dmem_we, reg_we, wb_sel, state, illegal, timeout, halted};
  endfunction

  // Entered and left at posedge+1; runs at most 'limit' queued cycles.
  task automatic exec_trace(input string name, input int limit);
    stim_t s;
    obs_t  e;
    int    n;
    n = (exp_q.size() < limit) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      instr = s.instr; imem_ready = s.imem_ready;
      dmem_ready = s.dmem_ready; branch_taken = s.taken;
      @(negedge clk);
      check_eq($sformatf("%s.c%0d", name, i), 32'(sample()), 32'(e));
      @(posedge clk); #1;
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic reset_dut(input string name);
    rstn = 1'b0;
    #2;
    check_eq({name, ".rst"}, 32'(sample()), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ext = 3'd0;
    m_halt = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] ins, input int iw,
                     input int dw, input logic tk);
    build(ins, iw, dw, tk);
    exec_trace(name, 1000);
    if (m_halt) reset_dut(name);
  endtask

  logic [6:0] legal_opc [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    rstn = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    m_ext = 3'd0; m_halt = 1'b0; cur_ins = '0;
    @(posedge clk); #1;
    reset_dut("init");

    run("addi",   32'h00500093, 0, 0, 1'b0);
    run("beq_t",  32'h00000463, 0, 0, 1'b1);
    run("beq_n",  32'h00000463, 0, 0, 1'b0);
    run("lw_w3",  32'h00012083, 0, 3, 1'b0);
    run("sw",     32'h00112223, 0, 0, 1'b0);
    run("jal",    32'h008000EF, 0, 0, 1'b0);
    run("jalr",   32'h000080E7, 2, 0, 1'b0);
    run("lui",    32'h123450B7, 1, 0, 1'b0);
    run("auipc",  32'h00001097, 0, 0, 1'b0);
    run("add",    32'h002081B3, 3, 0, 1'b0);
    run("sw_w3",  32'h00112223, 3, 3, 1'b0);
    run("illeg",  32'h0000007F, 0, 0, 1'b0);
    run("ecall",  32'h00000073, 0, 0, 1'b0);
    run("to_if",  32'h00500093, 4, 0, 1'b0);
    run("to_mem", 32'h00012083, 0, 4, 1'b0);

    // Reset pulse while a load sits in MEM: F,D,E then two MEM wait cycles.
    build(32'h00012083, 0, 3, 1'b0);
    exec_trace("lw_abort", 5);
    reset_dut("lw_abort");
    run("post_rst", 32'h00500093, 0, 0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      r = $urandom();
      if ($urandom_range(0, 14) == 0) begin
        opc = 7'h7F;
        for (int t = 0; t < 20; t++) begin
          opc = 7'($urandom_range(0, 127));
          if (!(opc inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33}))
            break;
        end
        if (opc inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33})
          opc = 7'h7F;
      end else begin
        opc = legal_opc[$urandom_range(0, 8)];
      end
      run($sformatf("rnd%0d", k), {r[31:7], opc},
          ($urandom_range(0, 19) == 0) ? 4 : int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0) ? 4 : int'($urandom_range(0, 3)),
          rb());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
